// File: rtl/alu_reservation_station_if.sv
// alu_reservation_station_if: dispatch, CDB and issue bundle of the ALU reservation station
interface alu_reservation_station_if #(parameter int ID_W = 3);
  logic            dispatch_valid;
  logic [ID_W-1:0] dispatch_ins_id;
  logic [6:0]      dispatch_opcode;
  logic [2:0]      dispatch_funct3;
  logic [6:0]      dispatch_funct7;
  logic [31:0]     dispatch_imm;
  logic [31:0]     dispatch_PC;
  logic [5:0]      dispatch_shamt;
  logic            dispatch_is_compressed;
  logic            dispatch_rs1_ready;
  logic            dispatch_rs2_ready;
  logic [31:0]     dispatch_rs1_val;
  logic [31:0]     dispatch_rs2_val;
  logic [ID_W-1:0] dispatch_rs1_tag;
  logic [ID_W-1:0] dispatch_rs2_tag;
  logic            rs_full;
  logic            cdb_valid;
  logic [ID_W-1:0] cdb_ins_id;
  logic [31:0]     cdb_val;
  logic            have_ins;
  logic [ID_W-1:0] ins_id;
  logic [31:0]     rs1_val;
  logic [31:0]     rs2_val;
  logic [31:0]     imm_val;
  logic [31:0]     request_PC;
  logic [5:0]      shamt_val;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic            is_compressed_ins;
  modport master (
    output dispatch_valid, dispatch_ins_id, dispatch_opcode, dispatch_funct3, dispatch_funct7,
           dispatch_imm, dispatch_PC, dispatch_shamt, dispatch_is_compressed,
           dispatch_rs1_ready, dispatch_rs2_ready, dispatch_rs1_val, dispatch_rs2_val,
           dispatch_rs1_tag, dispatch_rs2_tag, cdb_valid, cdb_ins_id, cdb_val,
    input  rs_full, have_ins, ins_id, rs1_val, rs2_val, imm_val, request_PC, shamt_val,
           opcode, funct3, funct7, is_compressed_ins
  );
  modport slave (
    input  dispatch_valid, dispatch_ins_id, dispatch_opcode, dispatch_funct3, dispatch_funct7,
           dispatch_imm, dispatch_PC, dispatch_shamt, dispatch_is_compressed,
           dispatch_rs1_ready, dispatch_rs2_ready, dispatch_rs1_val, dispatch_rs2_val,
           dispatch_rs1_tag, dispatch_rs2_tag, cdb_valid, cdb_ins_id, cdb_val,
    output rs_full, have_ins, ins_id, rs1_val, rs2_val, imm_val, request_PC, shamt_val,
           opcode, funct3, funct7, is_compressed_ins
  );
endinterface

// File: rtl/alu_reservation_station.sv
// alu_reservation_station: in-order-select ALU reservation station with CDB wakeup.
// Define ALU_RS_CDB_FORWARD_EN to let an entry issue in the same cycle its last operand is broadcast.
module alu_reservation_station #(
  parameter int RS_SIZE = 4,
  parameter int ID_W    = 3
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic rdy_in,
  input  logic flush_pipline,
  alu_reservation_station_if.slave io
);
  localparam int IDX_W = $clog2(RS_SIZE);
  logic [RS_SIZE-1:0] r_busy, r_rs1_rdy, r_rs2_rdy, r_comp;
  logic [31:0]        r_rs1_val [RS_SIZE];
  logic [31:0]        r_rs2_val [RS_SIZE];
  logic [31:0]        r_imm     [RS_SIZE];
  logic [31:0]        r_pc      [RS_SIZE];
  logic [ID_W-1:0]    r_rs1_tag [RS_SIZE];
  logic [ID_W-1:0]    r_rs2_tag [RS_SIZE];
  logic [ID_W-1:0]    r_id      [RS_SIZE];
  logic [6:0]         r_opcode  [RS_SIZE];
  logic [2:0]         r_funct3  [RS_SIZE];
  logic [6:0]         r_funct7  [RS_SIZE];
  logic [5:0]         r_shamt   [RS_SIZE];
  logic [RS_SIZE-1:0] w_wake1, w_wake2, w_elig;
  logic               w_iss_vld, w_accept, w_d_rs1_hit, w_d_rs2_hit;
  logic [IDX_W-1:0]   w_iss_idx, w_free_idx;
  logic [31:0]        w_iss_rs1, w_iss_rs2;
  // Descending scan so the lowest eligible / free index wins.
  always_comb begin
    w_iss_vld  = 1'b0;
    w_iss_idx  = '0;
    w_free_idx = '0;
    w_wake1    = '0;
    w_wake2    = '0;
    w_elig     = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      w_wake1[i] = io.cdb_valid && !r_rs1_rdy[i] && r_rs1_tag[i] == io.cdb_ins_id;
      w_wake2[i] = io.cdb_valid && !r_rs2_rdy[i] && r_rs2_tag[i] == io.cdb_ins_id;
`ifdef ALU_RS_CDB_FORWARD_EN
      w_elig[i]  = r_busy[i] && (r_rs1_rdy[i] || w_wake1[i]) && (r_rs2_rdy[i] || w_wake2[i]);
`else
      w_elig[i]  = r_busy[i] && r_rs1_rdy[i] && r_rs2_rdy[i];
`endif
      if (w_elig[i]) begin
        w_iss_vld = 1'b1;
        w_iss_idx = IDX_W'(i);
      end
      if (!r_busy[i]) w_free_idx = IDX_W'(i);
    end
  end
`ifdef ALU_RS_CDB_FORWARD_EN
  assign w_iss_rs1 = r_rs1_rdy[w_iss_idx] ? r_rs1_val[w_iss_idx] : io.cdb_val;
  assign w_iss_rs2 = r_rs2_rdy[w_iss_idx] ? r_rs2_val[w_iss_idx] : io.cdb_val;
`else
  assign w_iss_rs1 = r_rs1_val[w_iss_idx];
  assign w_iss_rs2 = r_rs2_val[w_iss_idx];
`endif
  assign io.rs_full  = &r_busy;
  assign w_accept    = io.dispatch_valid && !io.rs_full && !flush_pipline;
  assign w_d_rs1_hit = io.cdb_valid && io.cdb_ins_id == io.dispatch_rs1_tag;
  assign w_d_rs2_hit = io.cdb_valid && io.cdb_ins_id == io.dispatch_rs2_tag;
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_busy               <= '0;
      io.have_ins          <= 1'b0;
      io.ins_id            <= '0;
      io.rs1_val           <= '0;
      io.rs2_val           <= '0;
      io.imm_val           <= '0;
      io.request_PC        <= '0;
      io.shamt_val         <= '0;
      io.opcode            <= '0;
      io.funct3            <= '0;
      io.funct7            <= '0;
      io.is_compressed_ins <= 1'b0;
    end else if (rdy_in) begin
      if (flush_pipline) begin
        r_busy      <= '0;
        io.have_ins <= 1'b0;
      end else begin
        for (int i = 0; i < RS_SIZE; i++) begin
          if (w_wake1[i]) begin
            r_rs1_rdy[i] <= 1'b1;
            r_rs1_val[i] <= io.cdb_val;
          end
          if (w_wake2[i]) begin
            r_rs2_rdy[i] <= 1'b1;
            r_rs2_val[i] <= io.cdb_val;
          end
        end
        io.have_ins <= w_iss_vld;
        if (w_iss_vld) begin
          r_busy[w_iss_idx]    <= 1'b0;
          io.ins_id            <= r_id[w_iss_idx];
          io.rs1_val           <= w_iss_rs1;
          io.rs2_val           <= w_iss_rs2;
          io.imm_val           <= r_imm[w_iss_idx];
          io.request_PC        <= r_pc[w_iss_idx];
          io.shamt_val         <= r_shamt[w_iss_idx];
          io.opcode            <= r_opcode[w_iss_idx];
          io.funct3            <= r_funct3[w_iss_idx];
          io.funct7            <= r_funct7[w_iss_idx];
          io.is_compressed_ins <= r_comp[w_iss_idx];
        end
        if (w_accept) begin
          r_busy[w_free_idx]    <= 1'b1;
          r_id[w_free_idx]      <= io.dispatch_ins_id;
          r_opcode[w_free_idx]  <= io.dispatch_opcode;
          r_funct3[w_free_idx]  <= io.dispatch_funct3;
          r_funct7[w_free_idx]  <= io.dispatch_funct7;
          r_imm[w_free_idx]     <= io.dispatch_imm;
          r_pc[w_free_idx]      <= io.dispatch_PC;
          r_shamt[w_free_idx]   <= io.dispatch_shamt;
          r_comp[w_free_idx]    <= io.dispatch_is_compressed;
          r_rs1_tag[w_free_idx] <= io.dispatch_rs1_tag;
          r_rs2_tag[w_free_idx] <= io.dispatch_rs2_tag;
          r_rs1_rdy[w_free_idx] <= io.dispatch_rs1_ready || w_d_rs1_hit;
          r_rs2_rdy[w_free_idx] <= io.dispatch_rs2_ready || w_d_rs2_hit;
          r_rs1_val[w_free_idx] <= io.dispatch_rs1_ready ? io.dispatch_rs1_val : io.cdb_val;
          r_rs2_val[w_free_idx] <= io.dispatch_rs2_ready ? io.dispatch_rs2_val : io.cdb_val;
        end
      end
    end
  end
endmodule
